// File: rtl/zombie_wave_controller.sv
`default_nettype none
// ============================================================================
// Module   : zombie_wave_controller
// Brief    : Level sequencer for the lawn game. Runs the level FSM, spawns
//            zombies into five lanes on a move-tick schedule, walks them
//            toward the house and applies kill events.
// Revision : 1.0 - initial release
// ============================================================================
module zombie_wave_controller #(
   parameter int         TICK_DIV    = 500000,
   parameter int         SPAWN_GAP   = 64,
   parameter logic [9:0] SPAWN_X     = 10'd639,
   parameter logic [9:0] END_OF_LAWN = 10'd0,
   parameter int         KILLS_L1    = 5,
   parameter int         KILLS_L2    = 10,
   parameter int         KILLS_L3    = 15,
   parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        kill_valid,
   input  logic [2:0]  kill_lane,
   output logic [4:0]  lane_active,
   output logic [49:0] zombie_x,
   output logic [7:0]  state,
   output logic [15:0] zombies_killed,
   output logic        move_tick,
   output logic        level_done
);

   localparam int c_PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int c_SPAWN_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
   localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
   localparam logic [c_SPAWN_W-1:0] c_GAP_LAST   = c_SPAWN_W'(SPAWN_GAP - 1);
   localparam logic [7:0] c_GOAL_L1 = 8'(KILLS_L1);
   localparam logic [7:0] c_GOAL_L2 = 8'(KILLS_L2);
   localparam logic [7:0] c_GOAL_L3 = 8'(KILLS_L3);

   // One-hot encoding doubles as the state vector seen by the pixel logic
   typedef enum logic [7:0] {
      ST_I     = 8'h01,
      ST_L1    = 8'h02,
      ST_NL2   = 8'h04,
      ST_L2    = 8'h08,
      ST_NL3   = 8'h10,
      ST_L3    = 8'h20,
      ST_DONEL = 8'h40,
      ST_DONEW = 8'h80
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   state_t                 w_clear_st;
   logic [c_PRESC_W-1:0]   r_presc;
   logic [c_SPAWN_W-1:0]   r_spawn_cnt;
   logic [c_SPAWN_W-1:0]   w_spawn_nxt;
   logic [7:0]             r_lfsr;
   logic [7:0]             r_lvl_cnt;
   logic [7:0]             w_lvl_nxt;
   logic [7:0]             w_goal;
   logic [4:0]             w_active_nxt;
   logic [4:0]             w_kill_mask;
   logic [49:0]            w_x_nxt;
   logic [15:0]            w_killed_nxt;
   logic [9:0]             w_step;
   logic [2:0]             w_cand;
   logic [2:0]             w_lane;
   logic [3:0]             w_probe;
   logic                   w_done_nxt;
   logic                   w_in_level;
   logic                   w_loss;
   logic                   w_spawn_try;
   logic                   w_found;

   assign state = r_state;

   // Level FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_I;
      else          r_state <= w_state_nxt;
   end

   // Free-running prescaler; move_tick marks the clock after each wrap
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_presc   <= '0;
         move_tick <= 1'b0;
      end else if (r_presc == c_PRESC_LAST) begin
         r_presc   <= '0;
         move_tick <= 1'b1;
      end else begin
         r_presc   <= r_presc + c_PRESC_W'(1);
         move_tick <= 1'b0;
      end
   end

   // Spawn-lane LFSR, x^8+x^6+x^5+x^4, shifting every clock
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_lfsr <= LFSR_SEED;
      else          r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
   end

   // Next state, kills, movement and spawn for the coming clock
   always_comb begin
      w_state_nxt  = r_state;
      w_clear_st   = ST_I;
      w_active_nxt = lane_active;
      w_x_nxt      = zombie_x;
      w_lvl_nxt    = r_lvl_cnt;
      w_killed_nxt = zombies_killed;
      w_spawn_nxt  = r_spawn_cnt;
      w_done_nxt   = 1'b0;
      w_in_level   = 1'b0;
      w_step       = 10'd0;
      w_goal       = 8'd0;
      w_loss       = 1'b0;
      w_spawn_try  = 1'b0;
      w_found      = 1'b0;
      w_lane       = 3'd0;
      w_probe      = 4'd0;
      w_kill_mask  = 5'd0;
      // Fold LFSR values 5/6/7 back onto lanes 0/1/2
      w_cand = (r_lfsr[2:0] > 3'd4) ? (r_lfsr[2:0] - 3'd5) : r_lfsr[2:0];

      case (r_state)
         ST_L1: begin
            w_in_level = 1'b1; w_step = 10'd1; w_goal = c_GOAL_L1; w_clear_st = ST_NL2;
         end
         ST_L2: begin
            w_in_level = 1'b1; w_step = 10'd2; w_goal = c_GOAL_L2; w_clear_st = ST_NL3;
         end
         ST_L3: begin
            w_in_level = 1'b1; w_step = 10'd3; w_goal = c_GOAL_L3; w_clear_st = ST_DONEW;
         end
         default: ;
      endcase

      for (int i = 0; i < 5; i++)
         w_kill_mask[i] = w_in_level && kill_valid && lane_active[i] && (kill_lane == 3'(i));

      if (w_in_level) begin
         if (|w_kill_mask) begin
            w_active_nxt = lane_active & ~w_kill_mask;
            w_lvl_nxt    = r_lvl_cnt + 8'd1;
            if (zombies_killed != 16'hFFFF)
               w_killed_nxt = zombies_killed + 16'd1;
         end
         if (move_tick) begin
            // A lane killed this clock is already inactive here, so it cannot lose
            for (int i = 0; i < 5; i++) begin
               if (w_active_nxt[i]) begin
                  if (zombie_x[10*i +: 10] <= END_OF_LAWN + w_step) begin
                     w_x_nxt[10*i +: 10] = END_OF_LAWN;
                     w_loss              = 1'b1;
                  end else begin
                     w_x_nxt[10*i +: 10] = zombie_x[10*i +: 10] - w_step;
                  end
               end
            end
            if (r_spawn_cnt == c_GAP_LAST) begin
               w_spawn_nxt = '0;
               w_spawn_try = 1'b1;
            end else begin
               w_spawn_nxt = r_spawn_cnt + c_SPAWN_W'(1);
            end
         end
         // Occupancy uses the pre-kill mask: a lane killed this clock stays taken
         if (w_spawn_try) begin
            for (int k = 0; k < 5; k++) begin
               w_probe = {1'b0, w_cand} + 4'(k);
               if (w_probe > 4'd4) w_probe = w_probe - 4'd5;
               if (!w_found && !lane_active[w_probe[2:0]]) begin
                  w_found = 1'b1;
                  w_lane  = w_probe[2:0];
               end
            end
         end
         if (w_found) begin
            w_active_nxt[w_lane]       = 1'b1;
            w_x_nxt[10*w_lane +: 10]   = SPAWN_X;
         end
         // Loss beats a simultaneous level-clearing kill
         if (w_loss) begin
            w_state_nxt  = ST_DONEL;
            w_active_nxt = 5'd0;
            w_lvl_nxt    = 8'd0;
         end else if (w_lvl_nxt >= w_goal) begin
            w_state_nxt  = w_clear_st;
            w_active_nxt = 5'd0;
            w_lvl_nxt    = 8'd0;
            w_done_nxt   = 1'b1;
         end
      end else if (start) begin
         case (r_state)
            ST_I: begin
               w_state_nxt  = ST_L1;
               w_killed_nxt = 16'd0;
               w_lvl_nxt    = 8'd0;
               w_active_nxt = 5'd0;
               w_spawn_nxt  = '0;
            end
            ST_NL2:             w_state_nxt = ST_L2;
            ST_NL3:             w_state_nxt = ST_L3;
            ST_DONEL, ST_DONEW: w_state_nxt = ST_I;
            default: ;
         endcase
      end
   end

   // Lane, score and spawn-schedule registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lane_active    <= 5'd0;
         zombie_x       <= {5{SPAWN_X}};
         zombies_killed <= 16'd0;
         r_lvl_cnt      <= 8'd0;
         r_spawn_cnt    <= '0;
         level_done     <= 1'b0;
      end else begin
         lane_active    <= w_active_nxt;
         zombie_x       <= w_x_nxt;
         zombies_killed <= w_killed_nxt;
         r_lvl_cnt      <= w_lvl_nxt;
         r_spawn_cnt    <= w_spawn_nxt;
         level_done     <= w_done_nxt;
      end
   end

endmodule
`default_nettype wire
